// File: rtl/inst_queue.sv
// Instruction queue: circular FIFO of fetched inst/PC pairs feeding the decoder.
// Latency: push-to-visible 1 cycle (0 cycles on an empty queue when INST_QUEUE_BYPASS_EN is defined).
// Backpressure: IF_is_full holds off the fetcher (pushes while full are dropped); rdy low freezes all state.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   rdy                - global ready; when low nothing changes
//   ROB_clear          - mispredict flush, discards every entry (wins over push/pop)
//   IF_valid/IF_inst/IF_pc - fetch side push request and payload
//   IF_is_full         - queue holds DEPTH entries
//   ID_enable          - decoder consumes the head entry this cycle
//   ID_queue_is_empty/ID_inst/ID_pc - head entry presented to the decoder (zeros when empty)
// Optional feature macro: INST_QUEUE_BYPASS_EN (fetch-to-decode combinational path on empty queue).

`ifndef IQEmpty
`define IQEmpty 1'b1
`endif

module inst_queue #(
  parameter int IQ_ADDR_WIDTH = 4,
  parameter int DEPTH         = 1 << IQ_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ROB_clear,
  input  logic        IF_valid,
  input  logic [31:0] IF_inst,
  input  logic [31:0] IF_pc,
  output logic        IF_is_full,
  input  logic        ID_enable,
  output logic        ID_queue_is_empty,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc
);

  localparam logic [IQ_ADDR_WIDTH:0] FULL_CNT = (IQ_ADDR_WIDTH + 1)'(DEPTH);

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [IQ_ADDR_WIDTH-1:0] head_q, head_d;
  logic [IQ_ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [IQ_ADDR_WIDTH:0]   count_q, count_d;

  logic q_empty;
  logic q_full;
  logic byp_vld;   // fetch word shown directly to ID this cycle
  logic byp_take;  // ...and consumed by ID, so it is never written
  logic flush;
  logic push;
  logic pop;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == FULL_CNT);

`ifdef INST_QUEUE_BYPASS_EN
  assign byp_vld  = q_empty && IF_valid && !ROB_clear;
  assign byp_take = byp_vld && ID_enable && rdy;
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign flush = ROB_clear && rdy;
  // Full check looks at the current count only: a same-cycle pop does not make room.
  assign push  = IF_valid && !q_full && !ROB_clear && rdy && !byp_take;
  assign pop   = ID_enable && !q_empty && !ROB_clear && rdy;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;  // pointers wrap modulo DEPTH
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= IF_inst;
      pc_mem[tail_q]   <= IF_pc;
    end
  end

  assign IF_is_full = q_full;

  always_comb begin
    ID_queue_is_empty = `IQEmpty;
    ID_inst           = '0;
    ID_pc             = '0;
    if (!q_empty) begin
      ID_queue_is_empty = ~`IQEmpty;
      ID_inst           = inst_mem[head_q];
      ID_pc             = pc_mem[head_q];
    end else if (byp_vld) begin
      ID_queue_is_empty = ~`IQEmpty;
      ID_inst           = IF_inst;
      ID_pc             = IF_pc;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Randomized + directed bench for inst_queue with a queue-based reference model.
// Stimulus drives just after the rising edge; the monitor checks on the falling edge.
// Build with or without INST_QUEUE_BYPASS_EN to match the RTL.
module tb_inst_queue;

  localparam int DEPTH = 16;
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ROB_clear;
  logic        IF_valid;
  logic [31:0] IF_inst;
  logic [31:0] IF_pc;
  logic        IF_is_full;
  logic        ID_enable;
  logic        ID_queue_is_empty;
  logic [31:0] ID_inst;
  logic [31:0] ID_pc;

  inst_queue dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .ROB_clear         (ROB_clear),
    .IF_valid          (IF_valid),
    .IF_inst           (IF_inst),
    .IF_pc             (IF_pc),
    .IF_is_full        (IF_is_full),
    .ID_enable         (ID_enable),
    .ID_queue_is_empty (ID_queue_is_empty),
    .ID_inst           (ID_inst),
    .ID_pc             (ID_pc)
  );

  always #5 clk = ~clk;

  ent_t        exp_q[$];   // expected queue contents, oldest first
  int          nchk  = 0;
  int          npass = 0;
  logic        mon_en = 1'b0;
  logic [31:0] last_pc = '0;
  logic        saw_100 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: compares every cycle against the model, pops on each consumption.
  int          m_sz;
  logic        m_byp;
  logic [31:0] m_inst, m_pc;
  always @(negedge clk) begin
    if (mon_en) begin
      m_sz  = exp_q.size();
      m_byp = BYP && (m_sz == 0) && IF_valid && !ROB_clear;
      m_inst = 32'h0;
      m_pc   = 32'h0;
      if (m_sz != 0) begin
        m_inst = exp_q[0].inst;
        m_pc   = exp_q[0].pc;
      end else if (m_byp) begin
        m_inst = IF_inst;
        m_pc   = IF_pc;
      end
      chk("mon_empty", 32'(ID_queue_is_empty), 32'((m_sz == 0) && !m_byp));
      chk("mon_full",  32'(IF_is_full),        32'(m_sz == DEPTH));
      chk("mon_count", 32'(dut.count_q),       32'(m_sz));
      chk("mon_inst",  ID_inst, m_inst);
      chk("mon_pc",    ID_pc,   m_pc);
      if (ID_enable && rdy && !ROB_clear && (m_sz != 0 || m_byp)) begin
        if (m_sz != 0) void'(exp_q.pop_front());
        last_pc = ID_pc;
        if (ID_pc == 32'h100) saw_100 = 1'b1;
      end
    end
  end

  // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic en, input logic clr, input logic r);
    logic push_acc, flush_acc, byp_take;
    IF_valid  = v;
    IF_inst   = inst;
    IF_pc     = pc;
    ID_enable = en;
    ROB_clear = clr;
    rdy       = r;
    byp_take  = BYP && v && !clr && r && en && (exp_q.size() == 0);
    push_acc  = v && r && !clr && (exp_q.size() < DEPTH) && !byp_take;
    flush_acc = clr && r;
    @(posedge clk);
    if (flush_acc) exp_q.delete();
    else if (push_acc) exp_q.push_back('{inst: inst, pc: pc});
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop1();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pcn;
    int          held;
    rst = 1'b1; rdy = 1'b1; ROB_clear = 1'b0; IF_valid = 1'b0;
    IF_inst = '0; IF_pc = '0; ID_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(ID_queue_is_empty), 32'd1);
    chk("rst_full",  32'(IF_is_full),        32'd0);
    chk("rst_inst",  ID_inst, 32'd0);
    chk("rst_pc",    ID_pc,   32'd0);
    chk("rst_count", 32'(dut.count_q), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic push of three, then drain in order.
    step(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00100093, 32'h4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00200113, 32'h8, 1'b0, 1'b0, 1'b1);
    idle();
    chk("t1_count3", 32'(dut.count_q), 32'd3);
    chk("t1_head_pc", ID_pc, 32'h0);
    chk("t1_not_empty", 32'(ID_queue_is_empty), 32'd0);
    repeat (3) pop1();
    chk("t1_last_pc", last_pc, 32'h8);
    chk("t1_empty", 32'(ID_queue_is_empty), 32'd1);
    chk("t1_inst0", ID_inst, 32'd0);

    // Fill to full, dropped push, pop does not free a slot in the same cycle.
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    chk("t2_full", 32'(IF_is_full), 32'd1);
    step(1'b1, 32'h40404040, 32'h40, 1'b0, 1'b0, 1'b1);
    chk("t2_count_hold", 32'(dut.count_q), 32'd16);
    step(1'b1, 32'h40404040, 32'h40, 1'b1, 1'b0, 1'b1);
    chk("t2_after_pop", 32'(dut.count_q), 32'd15);
    step(1'b1, 32'h40404040, 32'h40, 1'b0, 1'b0, 1'b1);
    chk("t2_refull", 32'(IF_is_full), 32'd1);
    repeat (DEPTH + 1) pop1();
    chk("t2_last_is_40", last_pc, 32'h40);

    // Wrap-around with small occupancy.
    pcn = 32'h2000;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b1, $urandom, pcn, 1'b0, 1'b0, 1'b1);
        pcn += 4;
      end
      repeat (3) pop1();
    end
    chk("t3_last_pc", last_pc, pcn - 32'd4);

    // Flush beats push and pop; the wrong-path fetch vanishes.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 32'h3000 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hdeadbeef, 32'h100, 1'b1, 1'b1, 1'b1);
    chk("t4_count0", 32'(dut.count_q), 32'd0);
    chk("t4_empty", 32'(ID_queue_is_empty), 32'd1);
    repeat (3) pop1();
    chk("t4_no_100", 32'(saw_100), 32'd0);

    // rdy low freezes everything.
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 32'h4000 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    held = exp_q.size();
    for (int i = 0; i < 3; i++)
      step(1'(i), $urandom, 32'h5000, 1'(i + 1), 1'(i == 1), 1'b0);
    chk("t5_count_frozen", 32'(dut.count_q), 32'(held));
    chk("t5_head_frozen", ID_pc, 32'h4000);

    // Asynchronous reset between edges drops entries immediately.
    IF_valid = 1'b0; ID_enable = 1'b0; ROB_clear = 1'b0; rdy = 1'b1;
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t5_arst_empty", 32'(ID_queue_is_empty), 32'd1);
    chk("t5_arst_inst", ID_inst, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    #1 mon_en = 1'b1;
    idle();

    // Fetch-to-ID on an empty queue.
    IF_valid = 1'b1; IF_inst = 32'h0badf00d; IF_pc = 32'h200;
    ID_enable = 1'b1; ROB_clear = 1'b0; rdy = 1'b1;
    #2;
    if (BYP) begin
      chk("t6_byp_pc", ID_pc, 32'h200);
      chk("t6_byp_nempty", 32'(ID_queue_is_empty), 32'd0);
    end else begin
      chk("t6_nobyp_empty", 32'(ID_queue_is_empty), 32'd1);
    end
    step(1'b1, 32'h0badf00d, 32'h200, 1'b1, 1'b0, 1'b1);
    if (BYP) chk("t6_byp_count0", 32'(dut.count_q), 32'd0);
    else     chk("t6_nobyp_next_pc", ID_pc, 32'h200);
    repeat (2) pop1();

    // Random traffic; the monitor checks every cycle.
    pcn = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, pcn,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 9) != 0));
      pcn += 4;
    end
    repeat (DEPTH + 2) pop1();
    chk("end_empty", 32'(ID_queue_is_empty), 32'd1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
